ball_ctl: RTL

BALL_CTL -- requirements
Module: ball_ctl

---
 rtl/ball_pkg.sv | 30 +++
 rtl/tick_gen.sv | 32 +++
 rtl/ball_ctl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared types and default geometry for the ball controller.
// The optional speed-up feature (BALL_SPEEDUP_EN) is consumed in ball_ctl.sv.
package ball_pkg;
    localparam int POS_W    = 12;
    localparam int SCORE_W  = 4;
    localparam int PERIOD_W = 32;

    localparam int DEF_TICK_PERIOD = 800_000;
    localparam int DEF_SCREEN_W    = 1024;
    localparam int DEF_SCREEN_H    = 768;
    localparam int DEF_BALL_R      = 10;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SCORED = 2'd2
    } state_t;

    // INC means rightwards for x and downwards for y.
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 4'd1;
    endfunction
endpackage

// File: rtl/tick_gen.sv
// Reloadable down-counter: ticks for one cycle each time it reaches zero while enabled.
module tick_gen
    import ball_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                reload_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);
    logic [PERIOD_W-1:0] count_q, count_d;

    assign tick_o = enable_i && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (reload_i || tick_o) begin
            count_d = period_i - PERIOD_W'(1);
        end else if (enable_i) begin
            count_d = count_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= period_i - PERIOD_W'(1);
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ball_ctl.sv
// Pong ball controller: serve, per-tick motion, wall/paddle bounces and scoring.
// Define BALL_SPEEDUP_EN to shorten the step period on every accepted paddle hit.
module ball_ctl
    import ball_pkg::*;
#(
    parameter int TICK_PERIOD = DEF_TICK_PERIOD,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int BALL_R      = DEF_BALL_R
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               serve,
    input  logic               hit_left,
    input  logic               hit_right,
    output logic [POS_W-1:0]   x_pos,
    output logic [POS_W-1:0]   y_pos,
    output logic               running,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               point_pulse
);
    localparam logic [POS_W-1:0]    X_CTR       = POS_W'(SCREEN_W / 2);
    localparam logic [POS_W-1:0]    Y_CTR       = POS_W'(SCREEN_H / 2);
    localparam logic [POS_W-1:0]    X_MIN       = POS_W'(BALL_R);
    localparam logic [POS_W-1:0]    Y_MIN       = POS_W'(BALL_R);
    localparam logic [POS_W-1:0]    X_MAX       = POS_W'(SCREEN_W - 1 - BALL_R);
    localparam logic [POS_W-1:0]    Y_MAX       = POS_W'(SCREEN_H - 1 - BALL_R);
    localparam logic [PERIOD_W-1:0] PERIOD_FULL = PERIOD_W'(TICK_PERIOD);

    state_t               state_q;
    logic [POS_W-1:0]     x_q, y_q;
    dir_t                 dx_q, dy_q, serve_dir_q;
    logic [SCORE_W-1:0]   score_l_q, score_r_q;
    logic                 pulse_q, running_q;
    logic [PERIOD_W-1:0]  period_d;
    logic                 tick;

    logic [POS_W-1:0]     x_step, y_step;
    dir_t                 dx_step, dy_step;
    logic                 miss_right, miss_left;

    tick_gen u_tick (
        .clk_i    (pclk),
        .reset_i  (reset),
        .enable_i (state_q == RUN),
        .reload_i (state_q != RUN),
        .period_i (period_d),
        .tick_o   (tick)
    );

    // A paddle hit takes priority over the edge, so a hit ball never scores.
    always_comb begin
        x_step     = x_q;
        dx_step    = dx_q;
        miss_right = 1'b0;
        miss_left  = 1'b0;
        if (dx_q == DIR_INC) begin
            if (hit_right) begin
                dx_step = DIR_DEC;
                x_step  = x_q - 12'd1;
            end else if (x_q == X_MAX) begin
                miss_right = 1'b1;
            end else begin
                x_step = x_q + 12'd1;
            end
        end else begin
            if (hit_left) begin
                dx_step = DIR_INC;
                x_step  = x_q + 12'd1;
            end else if (x_q == X_MIN) begin
                miss_left = 1'b1;
            end else begin
                x_step = x_q - 12'd1;
            end
        end

        dy_step = dy_q;
        if (dy_q == DIR_DEC && y_q == Y_MIN) begin
            dy_step = DIR_INC;
        end else if (dy_q == DIR_INC && y_q == Y_MAX) begin
            dy_step = DIR_DEC;
        end
        y_step = (dy_step == DIR_INC) ? y_q + 12'd1 : y_q - 12'd1;
    end

`ifdef BALL_SPEEDUP_EN
    localparam logic [PERIOD_W-1:0] PERIOD_STEP  = PERIOD_W'(TICK_PERIOD / 16);
    localparam logic [PERIOD_W-1:0] PERIOD_FLOOR = PERIOD_W'(TICK_PERIOD / 4);

    logic [PERIOD_W-1:0] period_q;
    logic                hit_acc;

    assign hit_acc = tick && ((dx_q == DIR_INC && hit_right) || (dx_q == DIR_DEC && hit_left));

    // Feeding the next period to the counter makes a hit's speed-up apply to the very next step.
    always_comb begin
        period_d = period_q;
        if (reset || (state_q == IDLE && serve)) begin
            period_d = PERIOD_FULL;
        end else if (hit_acc) begin
            period_d = (period_q < PERIOD_FLOOR + PERIOD_STEP) ? PERIOD_FLOOR
                                                              : period_q - PERIOD_STEP;
        end
    end

    always_ff @(posedge pclk) begin
        period_q <= period_d;
    end
`else
    assign period_d = PERIOD_FULL;
`endif

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= X_CTR;
            y_q         <= Y_CTR;
            dx_q        <= DIR_INC;
            dy_q        <= DIR_INC;
            serve_dir_q <= DIR_INC;
            score_l_q   <= '0;
            score_r_q   <= '0;
            pulse_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    x_q <= X_CTR;
                    y_q <= Y_CTR;
                    if (serve) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        dx_q      <= serve_dir_q;
                        dy_q      <= DIR_INC;
                    end
                end
                RUN: begin
                    // The player who missed serves next, so the ball leaves toward the scorer.
                    if (tick) begin
                        if (miss_right) begin
                            score_l_q   <= sat_inc(score_l_q);
                            serve_dir_q <= DIR_DEC;
                            state_q     <= SCORED;
                            running_q   <= 1'b0;
                            pulse_q     <= 1'b1;
                        end else if (miss_left) begin
                            score_r_q   <= sat_inc(score_r_q);
                            serve_dir_q <= DIR_INC;
                            state_q     <= SCORED;
                            running_q   <= 1'b0;
                            pulse_q     <= 1'b1;
                        end else begin
                            x_q  <= x_step;
                            y_q  <= y_step;
                            dx_q <= dx_step;
                            dy_q <= dy_step;
                        end
                    end
                end
                SCORED: begin
                    state_q <= IDLE;
                    x_q     <= X_CTR;
                    y_q     <= Y_CTR;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign running     = running_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign point_pulse = pulse_q;
endmodule
